// File: rtl/uart_xcvr_if.sv
// Register-side and pad-side signals of the UART transceiver.
// The slave modport is the transceiver; master is whatever drives it.
interface uart_xcvr_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       tx_o;
  logic       rx_i;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       rx_ready_i;
  logic       rx_frame_err_o;
  logic       rx_parity_err_o;
  logic       rx_overflow_o;

  modport slave (
    input  tx_valid_i, tx_data_i, rx_i, rx_ready_i,
    output tx_ready_o, tx_o, rx_valid_o, rx_data_o,
           rx_frame_err_o, rx_parity_err_o, rx_overflow_o
  );

  modport master (
    output tx_valid_i, tx_data_i, rx_i, rx_ready_i,
    input  tx_ready_o, tx_o, rx_valid_o, rx_data_o,
           rx_frame_err_o, rx_parity_err_o, rx_overflow_o
  );
endinterface

// File: rtl/uart_xcvr.sv
// Device-side UART: 8 data bits, optional parity, 1 stop bit, LSB first.
// state      | meaning
// IDLE       | line idle (TX: ready for a byte, RX: waiting for a low level)
// START/DATA | start bit / eight data bits, each CPB cycles
// PARITY/STOP| optional parity bit / stop bit
// BREAK      | RX only: line stuck low after a frame error, wait for high
module uart_xcvr #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic        clk_i,
  input logic        rst_ni,
  uart_xcvr_if.slave bus
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB < 4) ? 2 : $clog2(CPB);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  // Start bit is checked so that its sample lands CPB/2-1 cycles after the first low rxs cycle.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 2);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_xcvr: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  tx_state_t        tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]       tx_bit, tx_bit_nxt;
  logic [7:0]       tx_shift, tx_shift_nxt;
  logic             tx_par, tx_par_nxt;
  logic             tx_line, tx_line_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
      tx_line  <= tx_line_nxt;
    end
  end

  // tx_line is registered from the next-state decode so the pad never glitches.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_line_nxt  = tx_line;
    if (tx_state != TX_IDLE) tx_cnt_nxt = tx_cnt - CNT_W'(1);
    unique case (tx_state)
      TX_IDLE: begin
        tx_line_nxt = 1'b1;
        if (bus.tx_valid_i) begin
          tx_state_nxt = TX_START;
          tx_cnt_nxt   = BIT_LAST;
          tx_shift_nxt = bus.tx_data_i;
          tx_par_nxt   = (^bus.tx_data_i) ^ PARITY_ODD;
          tx_line_nxt  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_nxt = TX_DATA;
          tx_cnt_nxt   = BIT_LAST;
          tx_bit_nxt   = '0;
          tx_line_nxt  = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt = BIT_LAST;
          if (tx_bit == 3'd7) begin
            tx_state_nxt = PARITY_EN ? TX_PARITY : TX_STOP;
            tx_line_nxt  = PARITY_EN ? tx_par : 1'b1;
          end else begin
            tx_bit_nxt   = tx_bit + 3'd1;
            tx_shift_nxt = {1'b0, tx_shift[7:1]};
            tx_line_nxt  = tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_cnt == '0) begin
          tx_state_nxt = TX_STOP;
          tx_cnt_nxt   = BIT_LAST;
          tx_line_nxt  = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          tx_state_nxt = TX_IDLE;
          tx_line_nxt  = 1'b1;
        end
      end
      default: begin
        tx_state_nxt = TX_IDLE;
        tx_line_nxt  = 1'b1;
      end
    endcase
  end

  assign bus.tx_o       = tx_line;
  assign bus.tx_ready_o = (tx_state == TX_IDLE);

  logic             rx_s1, rxs;
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bit, rx_bit_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             rx_par_bad, rx_par_bad_nxt;
  logic             rx_done, rx_ferr_set, rx_perr_set;
  logic             rx_valid_q, ferr_q, perr_q, ovf_q;
  logic [7:0]       rx_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1      <= 1'b1;
      rxs        <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_s1      <= bus.rx_i;
      rxs        <= rx_s1;
      rx_state   <= rx_state_nxt;
      rx_cnt     <= rx_cnt_nxt;
      rx_bit     <= rx_bit_nxt;
      rx_shift   <= rx_shift_nxt;
      rx_par_bad <= rx_par_bad_nxt;
    end
  end

  always_comb begin
    rx_state_nxt   = rx_state;
    rx_cnt_nxt     = rx_cnt;
    rx_bit_nxt     = rx_bit;
    rx_shift_nxt   = rx_shift;
    rx_par_bad_nxt = rx_par_bad;
    rx_done        = 1'b0;
    rx_ferr_set    = 1'b0;
    rx_perr_set    = 1'b0;
    if (rx_state != RX_IDLE && rx_state != RX_BREAK) rx_cnt_nxt = rx_cnt - CNT_W'(1);
    unique case (rx_state)
      RX_IDLE: begin
        if (!rxs) begin
          rx_state_nxt   = RX_START;
          rx_cnt_nxt     = HALF_LAST;
          rx_par_bad_nxt = 1'b0;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          rx_state_nxt = rxs ? RX_IDLE : RX_DATA;
          rx_cnt_nxt   = BIT_LAST;
          rx_bit_nxt   = '0;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_nxt = {rxs, rx_shift[7:1]};
          rx_cnt_nxt   = BIT_LAST;
          if (rx_bit == 3'd7) rx_state_nxt = PARITY_EN ? RX_PARITY : RX_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end
      end
      RX_PARITY: begin
        if (rx_cnt == '0) begin
          rx_par_bad_nxt = rxs ^ (^rx_shift) ^ PARITY_ODD;
          rx_state_nxt   = RX_STOP;
          rx_cnt_nxt     = BIT_LAST;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          if (!rxs) begin
            rx_ferr_set  = 1'b1;
            rx_state_nxt = RX_BREAK;
          end else begin
            rx_perr_set  = rx_par_bad;
            rx_done      = !rx_par_bad;
            rx_state_nxt = RX_IDLE;
          end
        end
      end
      RX_BREAK: begin
        if (rxs) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Single-entry holding register; a consume in the completion cycle makes room for the new byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ferr_q <= rx_ferr_set;
      perr_q <= rx_perr_set;
      ovf_q  <= 1'b0;
      if (rx_done) begin
        if (!rx_valid_q || bus.rx_ready_i) begin
          rx_data_q  <= rx_shift;
          rx_valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_valid_o      = rx_valid_q;
  assign bus.rx_data_o       = rx_data_q;
  assign bus.rx_frame_err_o  = ferr_q;
  assign bus.rx_parity_err_o = perr_q;
  assign bus.rx_overflow_o   = ovf_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench: no-parity and even-parity transceivers at CPB=8, plus a CPB=5 loopback instance.
module tb_uart_xcvr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_l = 1'b0;
  logic rx_line = 1'b1;

  uart_xcvr_if if_a ();
  uart_xcvr_if if_p ();
  uart_xcvr_if if_l ();

  assign if_a.rx_i = rx_line;
  assign if_p.rx_i = rx_line;
  assign if_l.rx_i = if_l.tx_o;

  uart_xcvr #(.CLK_FREQ(8000000), .BAUD(1000000), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut_a (.clk_i(clk), .rst_ni(rst_a), .bus(if_a));
  uart_xcvr #(.CLK_FREQ(8000000), .BAUD(1000000), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    dut_p (.clk_i(clk), .rst_ni(rst_a), .bus(if_p));
  uart_xcvr #(.CLK_FREQ(8000000), .BAUD(1600000), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut_l (.clk_i(clk), .rst_ni(rst_l), .bus(if_l));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int a_vcnt = 0, a_ferr = 0, a_perr = 0, a_ovf = 0, a_rise = 0;
  int p_vcnt = 0, p_ferr = 0, p_perr = 0, p_rise = 0;
  logic [7:0] a_last = '0, p_last = '0;
  logic a_vprev = 1'b0, p_vprev = 1'b0;
  logic [7:0] rx_buf [0:1023];
  int rx_n = 0;
  logic [7:0] sent [0:255];

  always @(negedge clk) begin
    a_vprev <= if_a.rx_valid_o;
    if (if_a.rx_valid_o && !a_vprev) begin
      a_rise <= cyc;
      a_last <= if_a.rx_data_o;
    end
    if (if_a.rx_valid_o) a_vcnt <= a_vcnt + 1;
    a_ferr <= a_ferr + int'(if_a.rx_frame_err_o);
    a_perr <= a_perr + int'(if_a.rx_parity_err_o);
    a_ovf  <= a_ovf + int'(if_a.rx_overflow_o);
    p_vprev <= if_p.rx_valid_o;
    if (if_p.rx_valid_o && !p_vprev) begin
      p_rise <= cyc;
      p_last <= if_p.rx_data_o;
    end
    if (if_p.rx_valid_o) p_vcnt <= p_vcnt + 1;
    p_ferr <= p_ferr + int'(if_p.rx_frame_err_o);
    p_perr <= p_perr + int'(if_p.rx_parity_err_o);
    if (if_l.rx_valid_o && if_l.rx_ready_i && rx_n < 1024) begin
      rx_buf[rx_n] <= if_l.rx_data_o;
      rx_n <= rx_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par);
    rx_line = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      repeat (8) tick();
    end
    if (with_par) begin
      rx_line = par;
      repeat (8) tick();
    end
    rx_line = 1'b1;
    repeat (8) tick();
  endtask

  task automatic lb_send(input logic [7:0] b);
    int budget = 0;
    if_l.tx_valid_i = 1'b1;
    if_l.tx_data_i  = b;
    while (!if_l.tx_ready_o && budget < 200) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 200) begin
      errors++;
      $display("FAIL lb_handshake_timeout byte=%h", b);
    end
    tick();
    if_l.tx_valid_i = 1'b0;
  endtask

  task automatic check_tx_frame(input bit use_p, input logic [7:0] d, input logic [10:0] fb,
                                input int nb);
    logic txo, rdy;
    rdy = use_p ? if_p.tx_ready_o : if_a.tx_ready_o;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_before got=%b exp=1", rdy);
    end
    if (use_p) begin if_p.tx_valid_i = 1'b1; if_p.tx_data_i = d; end
    else       begin if_a.tx_valid_i = 1'b1; if_a.tx_data_i = d; end
    tick();
    if (use_p) begin if_p.tx_valid_i = 1'b0; if_p.tx_data_i = 8'hFF; end
    else       begin if_a.tx_valid_i = 1'b0; if_a.tx_data_i = 8'hFF; end
    for (int c = 1; c <= nb * 8; c++) begin
      txo = use_p ? if_p.tx_o : if_a.tx_o;
      rdy = use_p ? if_p.tx_ready_o : if_a.tx_ready_o;
      checks++;
      if (txo !== fb[(c - 1) / 8] || rdy !== 1'b0) begin
        errors++;
        $display("FAIL tx_bit cyc=%0d tx_o=%b exp=%b ready=%b exp=0", c, txo, fb[(c - 1) / 8], rdy);
      end
      tick();
    end
    txo = use_p ? if_p.tx_o : if_a.tx_o;
    rdy = use_p ? if_p.tx_ready_o : if_a.tx_ready_o;
    checks++;
    if (rdy !== 1'b1 || txo !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_return cyc=%0d ready=%b tx_o=%b exp=1,1", nb * 8 + 1, rdy, txo);
    end
  endtask

  task automatic test_reset();
    rx_line = 1'b1;
    if_a.tx_valid_i = 1'b0; if_a.tx_data_i = '0; if_a.rx_ready_i = 1'b1;
    if_p.tx_valid_i = 1'b0; if_p.tx_data_i = '0; if_p.rx_ready_i = 1'b1;
    if_l.tx_valid_i = 1'b0; if_l.tx_data_i = '0; if_l.rx_ready_i = 1'b1;
    rst_a = 1'b0;
    rst_l = 1'b0;
    repeat (3) tick();
    checks++;
    if (if_a.tx_o !== 1'b1 || if_a.tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx tx_o=%b ready=%b exp=1,1", if_a.tx_o, if_a.tx_ready_o);
    end
    checks++;
    if (if_a.rx_valid_o !== 1'b0 || if_a.rx_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx valid=%b data=%h exp=0,00", if_a.rx_valid_o, if_a.rx_data_o);
    end
    checks++;
    if ({if_a.rx_frame_err_o, if_a.rx_parity_err_o, if_a.rx_overflow_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err got=%b%b%b exp=000", if_a.rx_frame_err_o,
               if_a.rx_parity_err_o, if_a.rx_overflow_o);
    end
    checks++;
    if (if_l.tx_o !== 1'b1 || if_l.rx_valid_o !== 1'b0 || if_p.tx_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_other l_tx=%b l_valid=%b p_tx=%b exp=1,0,1", if_l.tx_o,
               if_l.rx_valid_o, if_p.tx_o);
    end
    rst_a = 1'b1;
    rst_l = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_tx_basic();
    check_tx_frame(1'b0, 8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10);
  endtask

  task automatic test_tx_back_to_back();
    int first = -1, second = -1, budget = 0;
    logic prev = 1'b1;
    if_a.tx_valid_i = 1'b1;
    if_a.tx_data_i  = 8'hFF;
    while (second < 0 && budget < 300) begin
      tick();
      budget++;
      if (prev && !if_a.tx_o) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
      prev = if_a.tx_o;
    end
    if_a.tx_valid_i = 1'b0;
    checks++;
    if (second - first !== 81) begin
      errors++;
      $display("FAIL tx_b2b_spacing got=%0d exp=81", second - first);
    end
    repeat (90) tick();
  endtask

  task automatic test_rx_basic();
    int v0 = a_vcnt, f0 = a_ferr, p0 = a_perr, o0 = a_ovf, st;
    if_a.rx_ready_i = 1'b1;
    st = cyc;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) tick();
    checks++;
    if (a_vcnt - v0 !== 1 || a_last !== 8'h3C) begin
      errors++;
      $display("FAIL rx_basic valid_cycles=%0d data=%h exp=1,3c", a_vcnt - v0, a_last);
    end
    checks++;
    if (a_rise !== st + 78) begin
      errors++;
      $display("FAIL rx_latency got=%0d exp=%0d", a_rise - st, 78);
    end
    checks++;
    if (a_ferr != f0 || a_perr != p0 || a_ovf != o0) begin
      errors++;
      $display("FAIL rx_basic_err ferr=%0d perr=%0d ovf=%0d exp=0,0,0", a_ferr - f0,
               a_perr - p0, a_ovf - o0);
    end
  endtask

  task automatic test_overflow();
    int o0 = a_ovf, st;
    if_a.rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    repeat (20) tick();
    checks++;
    if (if_a.rx_valid_o !== 1'b1 || if_a.rx_data_o !== 8'h11) begin
      errors++;
      $display("FAIL ovf_hold valid=%b data=%h exp=1,11", if_a.rx_valid_o, if_a.rx_data_o);
    end
    checks++;
    if (a_ovf - o0 !== 1) begin
      errors++;
      $display("FAIL ovf_pulses got=%0d exp=1", a_ovf - o0);
    end
    if_a.rx_ready_i = 1'b1;
    tick();
    if_a.rx_ready_i = 1'b0;
    checks++;
    if (if_a.rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_consume valid=%b exp=0", if_a.rx_valid_o);
    end
    o0 = a_ovf;
    send_frame(8'h11, 1'b0, 1'b0);
    st = cyc;
    fork
      send_frame(8'h22, 1'b0, 1'b0);
      begin
        repeat (77) tick();
        if_a.rx_ready_i = 1'b1;
        tick();
        if_a.rx_ready_i = 1'b0;
      end
    join
    repeat (10) tick();
    checks++;
    if (if_a.rx_valid_o !== 1'b1 || if_a.rx_data_o !== 8'h22) begin
      errors++;
      $display("FAIL same_cycle_load valid=%b data=%h exp=1,22 (start %0d)", if_a.rx_valid_o,
               if_a.rx_data_o, st);
    end
    checks++;
    if (a_ovf != o0) begin
      errors++;
      $display("FAIL same_cycle_ovf got=%0d exp=0", a_ovf - o0);
    end
    if_a.rx_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_glitch_break();
    int v0 = a_vcnt, f0 = a_ferr, p0 = a_perr;
    if_a.rx_ready_i = 1'b1;
    rx_line = 1'b0;
    repeat (3) tick();
    rx_line = 1'b1;
    repeat (40) tick();
    checks++;
    if (a_vcnt != v0 || a_ferr != f0 || a_perr != p0) begin
      errors++;
      $display("FAIL glitch valid=%0d ferr=%0d perr=%0d exp=0,0,0", a_vcnt - v0, a_ferr - f0,
               a_perr - p0);
    end
    rx_line = 1'b0;
    repeat (240) tick();
    rx_line = 1'b1;
    repeat (16) tick();
    checks++;
    if (a_ferr - f0 !== 1 || a_vcnt != v0) begin
      errors++;
      $display("FAIL break ferr=%0d valid=%0d exp=1,0", a_ferr - f0, a_vcnt - v0);
    end
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (20) tick();
    checks++;
    if (a_vcnt - v0 !== 1 || a_last !== 8'h55) begin
      errors++;
      $display("FAIL after_break valid=%0d data=%h exp=1,55", a_vcnt - v0, a_last);
    end
  endtask

  task automatic test_parity();
    int v0, pe0, f0, st;
    check_tx_frame(1'b1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    rx_line = 1'b1;
    repeat (100) tick();
    v0 = p_vcnt; pe0 = p_perr; f0 = p_ferr;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (20) tick();
    checks++;
    if (p_perr - pe0 !== 1 || p_vcnt != v0 || p_ferr != f0) begin
      errors++;
      $display("FAIL parity_err perr=%0d valid=%0d ferr=%0d exp=1,0,0", p_perr - pe0,
               p_vcnt - v0, p_ferr - f0);
    end
    pe0 = p_perr;
    st = cyc;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (20) tick();
    checks++;
    if (p_vcnt - v0 !== 1 || p_last !== 8'h07 || p_perr != pe0) begin
      errors++;
      $display("FAIL parity_ok valid=%0d data=%h perr=%0d exp=1,07,0", p_vcnt - v0, p_last,
               p_perr - pe0);
    end
    checks++;
    if (p_rise !== st + 86) begin
      errors++;
      $display("FAIL parity_latency got=%0d exp=86", p_rise - st);
    end
  endtask

  task automatic test_loopback();
    int base = rx_n, budget = 0;
    if_l.rx_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sent[i] = 8'($urandom_range(0, 255));
      lb_send(sent[i]);
    end
    while (rx_n - base < 256 && budget < 2000) begin
      tick();
      budget++;
    end
    checks++;
    if (rx_n - base !== 256) begin
      errors++;
      $display("FAIL lb_count got=%0d exp=256", rx_n - base);
    end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (rx_buf[base + i] !== sent[i]) begin
        errors++;
        $display("FAIL lb_byte idx=%0d got=%h exp=%h", i, rx_buf[base + i], sent[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, budget = 0;
    if_l.rx_ready_i = 1'b0;
    lb_send(8'h5A);
    while (!if_l.rx_valid_o && budget < 200) begin
      tick();
      budget++;
    end
    checks++;
    if (if_l.rx_valid_o !== 1'b1 || if_l.rx_data_o !== 8'h5A) begin
      errors++;
      $display("FAIL lb_held valid=%b data=%h exp=1,5a", if_l.rx_valid_o, if_l.rx_data_o);
    end
    lb_send(8'h00);
    repeat (20) tick();
    checks++;
    if (if_l.tx_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_low tx_o=%b exp=0", if_l.tx_o);
    end
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if (if_l.tx_o !== 1'b1 || if_l.rx_valid_o !== 1'b0 || if_l.tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_reset tx_o=%b valid=%b ready=%b exp=1,0,1", if_l.tx_o,
               if_l.rx_valid_o, if_l.tx_ready_o);
    end
    tick();
    tick();
    rst_l = 1'b1;
    if_l.rx_ready_i = 1'b1;
    repeat (4) tick();
    base = rx_n;
    lb_send(8'h01);
    lb_send(8'h80);
    lb_send(8'hC3);
    budget = 0;
    while (rx_n - base < 3 && budget < 500) begin
      tick();
      budget++;
    end
    checks++;
    if (rx_n - base !== 3 || rx_buf[base] !== 8'h01 || rx_buf[base + 1] !== 8'h80 ||
        rx_buf[base + 2] !== 8'hC3) begin
      errors++;
      $display("FAIL resume count=%0d bytes=%h %h %h exp=3 01 80 c3", rx_n - base,
               rx_buf[base], rx_buf[base + 1], rx_buf[base + 2]);
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_back_to_back();
    test_rx_basic();
    test_overflow();
    test_glitch_break();
    test_parity();
    test_loopback();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
- Synthesizable device-side UART transceiver, 8 data bits, optional parity, 1 stop bit, LSB first.
- Sits between a peripheral register interface and the chip pads. It is the counterpart the simulation UART DPI model drives and samples.
- TX path: accepts bytes over a valid/ready handshake and serializes them.
- RX path: synchronizes the line, deserializes frames, and presents bytes through a single-entry valid/ready holding register with error pulses.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, bit rate. CPB = CLK_FREQ/BAUD (integer divide). Elaboration error if CPB < 4.
- PARITY_EN, 0, 1 inserts/checks a parity bit after D7.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- tx_valid_i  in  1  TX byte valid
- tx_data_i  in  8  TX byte
- tx_ready_o  out  1  TX idle, able to accept a byte
- tx_o  out  1  serial out, idle high
- rx_i  in  1  serial in, asynchronous to clk_i
- rx_valid_o  out  1  RX byte available
- rx_data_o  out  8  RX byte
- rx_ready_i  in  1  consumer accepts RX byte
- rx_frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- rx_parity_err_o  out  1  one-cycle pulse: parity mismatch
- rx_overflow_o  out  1  one-cycle pulse: completed byte dropped

Behaviour:
- Definitions:
  - Everything is on posedge clk_i.
  - N = 10 + PARITY_EN bits per frame.
  - All bit periods are exactly CPB cycles.
- Reset values (asynchronous, active-low):
  - tx_o=1, tx_ready_o=1.
  - rx_valid_o=0, rx_data_o=0, all error pulses 0.
  - Synchronizer flops=1, both FSMs in IDLE.
  - Reset mid-frame aborts the frame immediately: tx_o goes high, the partial RX byte is discarded.
- TX FSM: IDLE -> START -> DATA(8) -> [PARITY] -> STOP -> IDLE.
  - tx_ready_o=1 only in IDLE.
  - tx_valid_i & tx_ready_o captures tx_data_i. The next cycle tx_o=0 (start bit) and tx_ready_o=0.
  - Then D0..D7, then parity (XOR of data, inverted if PARITY_ODD), then stop=1. Each bit lasts CPB cycles.
  - tx_ready_o returns to 1 in the cycle after the last stop cycle.
  - With tx_valid_i held high, consecutive start bits are N*CPB+1 cycles apart.
  - tx_data_i is ignored outside the handshake cycle. tx_valid_i may be deasserted without penalty.
- RX synchronizer: two flops on rx_i. All RX logic uses the second flop output (rxs).
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus BREAK.
  - IDLE: rxs=0 enters START and clears the bit counter.
  - START:
    - Sample rxs at count CPB/2-1.
    - If rxs=1, treat as a glitch: return to IDLE with no output.
    - Otherwise enter DATA.
  - DATA: sample every CPB cycles, shift into D0..D7.
  - PARITY: one sample. A mismatch is recorded for the STOP decision.
  - STOP, one sample:
    - rxs=0: rx_frame_err_o pulses, byte discarded, go to BREAK.
    - Else if parity mismatch: rx_parity_err_o pulses, byte discarded, go to IDLE.
    - Else: byte completes, go to IDLE.
  - BREAK: wait for rxs=1, then IDLE. A held-low line yields exactly one frame error.
- RX holding register (completion cycle = cycle after the stop sample):
  - rx_valid_o=0 at completion: load rx_data_o, set rx_valid_o.
  - rx_valid_o & rx_ready_i: clear rx_valid_o, unless a byte completes in the same cycle. In that case load the new byte and keep rx_valid_o=1, with no overflow.
  - rx_valid_o=1 & !rx_ready_i at completion: keep the old byte, drop the new one, pulse rx_overflow_o.
  - rx_data_o is stable while rx_valid_o=1.
- Latency: the stop sample falls CPB/2-1 + (N-1)*CPB cycles after the first rxs=0 cycle. rx_valid_o rises one cycle later.
- TX and RX are fully independent. Loopback (tx_o to rx_i) must work.

Test Plan (CLK_FREQ=8000000, BAUD=1000000, CPB=8 unless noted):
- TX 0xA5, PARITY_EN=0:
  - tx_o low for 8 cycles starting 1 cycle after the handshake, then 1,0,1,0,0,1,0,1 at 8 cycles each, then stop high 8 cycles.
  - tx_ready_o high on cycle 81 after the handshake.
- RX 0x3C driven at the exact bit period, rx_ready_i=1 -> one-cycle rx_valid_o with rx_data_o=0x3C. No error pulses.
- RX two bytes 0x11, 0x22 back-to-back with rx_ready_i=0 -> rx_data_o stays 0x11, rx_valid_o=1, rx_overflow_o pulses once. Repeat with rx_ready_i=1 on the second completion cycle -> 0x22 loaded, no overflow.
- 3-cycle low glitch on rx_i -> no rx_valid_o, no error pulses. Then hold rx_i low for 30 bit periods -> exactly one rx_frame_err_o. Release, then send 0x55 -> received correctly.
- PARITY_EN=1, PARITY_ODD=0:
  - TX 0x07 -> parity bit 1, frame 11 bits.
  - RX 0x07 with parity bit 0 -> rx_parity_err_o pulse, no rx_valid_o.
- Loopback with BAUD such that CPB=5, 256 random bytes -> all received in order. Assert rst_ni low mid-frame -> tx_o=1 and rx_valid_o=0 immediately. Traffic resumes after release.
